camellia_subkey_sequencer: RTL and testbench

//  Sequences the 26 Camellia-128 subkeys (kw1-4, k1-18, kL1-4) from the subkey generator, one step per accepted

---
 rtl/camellia_subkey_sequencer_if.sv | 20 ++
 rtl/camellia_subkey_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_camellia_subkey_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/camellia_subkey_sequencer_if.sv
// Subkey stream between the sequencer (master) and the round engine (slave).
// One step is transferred on each cycle where key_valid and key_ack are both high.
interface camellia_subkey_sequencer_if;
  logic        key_valid;
  logic        key_ack;
  logic [63:0] key_a;
  logic [63:0] key_b;
  logic [1:0]  step_kind;
  logic [4:0]  round_idx;

  modport master (
    output key_valid, key_a, key_b, step_kind, round_idx,
    input  key_ack
  );

  modport slave (
    input  key_valid, key_a, key_b, step_kind, round_idx,
    output key_ack
  );
endinterface

// File: rtl/camellia_subkey_sequencer.sv
// Steps through the 22 Camellia-128 subkey steps (whitening, rounds, FL pairs) in
// encrypt or decrypt order, one step per accepted handshake on the key stream.
module camellia_subkey_sequencer #(
  parameter int NSTEPS = 22,
  parameter int STEP_W = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        decrypt,
  input  logic        keys_ready,
  input  logic [63:0] kw1,
  input  logic [63:0] kw2,
  input  logic [63:0] kw3,
  input  logic [63:0] kw4,
  input  logic [63:0] k1,
  input  logic [63:0] k2,
  input  logic [63:0] k3,
  input  logic [63:0] k4,
  input  logic [63:0] k5,
  input  logic [63:0] k6,
  input  logic [63:0] k7,
  input  logic [63:0] k8,
  input  logic [63:0] k9,
  input  logic [63:0] k10,
  input  logic [63:0] k11,
  input  logic [63:0] k12,
  input  logic [63:0] k13,
  input  logic [63:0] k14,
  input  logic [63:0] k15,
  input  logic [63:0] k16,
  input  logic [63:0] k17,
  input  logic [63:0] k18,
  input  logic [63:0] kL1,
  input  logic [63:0] kL2,
  input  logic [63:0] kL3,
  input  logic [63:0] kL4,
  camellia_subkey_sequencer_if.master ks,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] KIND_PRE   = 2'd0;
  localparam logic [1:0] KIND_ROUND = 2'd1;
  localparam logic [1:0] KIND_FL    = 2'd2;
  localparam logic [1:0] KIND_POST  = 2'd3;

  localparam logic [STEP_W-1:0] FL1_STEP  = STEP_W'(7);
  localparam logic [STEP_W-1:0] FL2_STEP  = STEP_W'(14);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_KEYS, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              dir_q, dir_d;
  logic              valid;

  logic [17:0][63:0] rk;
  logic [1:0]        kind;
  logic [4:0]        ridx;
  logic [4:0]        key_idx;
  logic [63:0]       sel_a;
  logic [63:0]       sel_b;

  function automatic logic [1:0] kind_of(input logic [STEP_W-1:0] s);
    logic [1:0] k;
    if (s == '0)                            k = KIND_PRE;
    else if (s == FL1_STEP || s == FL2_STEP) k = KIND_FL;
    else if (s == LAST_STEP)                k = KIND_POST;
    else                                    k = KIND_ROUND;
    return k;
  endfunction

  // Round numbering skips the two FL steps, so later segments shift down by 1 and 2.
  function automatic logic [4:0] round_of(input logic [STEP_W-1:0] s);
    logic [4:0] r;
    r = '0;
    if (kind_of(s) == KIND_ROUND) begin
      if (s < FL1_STEP)      r = 5'(s);
      else if (s < FL2_STEP) r = 5'(s - STEP_W'(1));
      else                   r = 5'(s - STEP_W'(2));
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      step_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dir_d   = dir_q;
    valid   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d   = decrypt;
          step_d  = '0;
          state_d = keys_ready ? RUN : WAIT_KEYS;
        end
      end
      WAIT_KEYS: begin
        busy = 1'b1;
        if (keys_ready) state_d = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        valid = 1'b1;
        // An ack in the same cycle keys_ready falls still consumes the step.
        if (ks.key_ack) begin
          if (step_q == LAST_STEP) begin
            step_d  = '0;
            state_d = DONE;
          end else begin
            step_d  = step_q + STEP_W'(1);
            if (!keys_ready) state_d = WAIT_KEYS;
          end
        end else if (!keys_ready) begin
          state_d = WAIT_KEYS;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rk = {k18, k17, k16, k15, k14, k13, k12, k11, k10,
               k9, k8, k7, k6, k5, k4, k3, k2, k1};

  always_comb begin
    kind    = kind_of(step_q);
    ridx    = round_of(step_q);
    key_idx = dir_q ? (5'd19 - ridx) : ridx;
    sel_a   = '0;
    sel_b   = '0;
    case (kind)
      KIND_PRE: begin
        sel_a = dir_q ? kw3 : kw1;
        sel_b = dir_q ? kw4 : kw2;
      end
      KIND_ROUND: begin
        for (int i = 1; i <= 18; i++) begin
          if (key_idx == 5'(i)) sel_a = rk[i-1];
        end
      end
      KIND_FL: begin
        if (step_q == FL1_STEP) begin
          sel_a = dir_q ? kL4 : kL1;
          sel_b = dir_q ? kL3 : kL2;
        end else begin
          sel_a = dir_q ? kL2 : kL3;
          sel_b = dir_q ? kL1 : kL4;
        end
      end
      default: begin
        sel_a = dir_q ? kw1 : kw3;
        sel_b = dir_q ? kw2 : kw4;
      end
    endcase
  end

  assign ks.key_valid = valid;
  assign ks.key_a     = valid ? sel_a : '0;
  assign ks.key_b     = valid ? sel_b : '0;
  assign ks.step_kind = valid ? kind  : 2'd0;
  assign ks.round_idx = valid ? ridx  : 5'd0;

endmodule

// File: tb/tb_camellia_subkey_sequencer.sv
// Randomized bench for camellia_subkey_sequencer against a schedule-table model.
module tb_camellia_subkey_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, decrypt, keys_ready;
  logic        busy, done;
  logic [63:0] kw [1:4];
  logic [63:0] k  [1:18];
  logic [63:0] kl [1:4];

  camellia_subkey_sequencer_if ks();

  always #5 CLK = ~CLK;

  camellia_subkey_sequencer #(.NSTEPS(22), .STEP_W(5)) dut (
    .CLK(CLK), .RST(RST), .start(start), .decrypt(decrypt), .keys_ready(keys_ready),
    .kw1(kw[1]), .kw2(kw[2]), .kw3(kw[3]), .kw4(kw[4]),
    .k1(k[1]), .k2(k[2]), .k3(k[3]), .k4(k[4]), .k5(k[5]), .k6(k[6]),
    .k7(k[7]), .k8(k[8]), .k9(k[9]), .k10(k[10]), .k11(k[11]), .k12(k[12]),
    .k13(k[13]), .k14(k[14]), .k15(k[15]), .k16(k[16]), .k17(k[17]), .k18(k[18]),
    .kL1(kl[1]), .kL2(kl[2]), .kL3(kl[3]), .kL4(kl[4]),
    .ks(ks), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] ea [22];
  logic [63:0] eb [22];
  int          ek [22];
  int          ei [22];
  int          n_exp;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_step(input int kind, input logic [63:0] a, input logic [63:0] b, input int idx);
    ea[n_exp] = a;
    eb[n_exp] = b;
    ek[n_exp] = kind;
    ei[n_exp] = idx;
    n_exp++;
  endtask

  // Expected schedule: prewhite, three 6-round segments separated by FL pairs, postwhite.
  task automatic build_exp(input bit dir);
    int r;
    r = 0;
    n_exp = 0;
    if (dir) add_step(0, kw[3], kw[4], 0);
    else     add_step(0, kw[1], kw[2], 0);
    for (int seg = 0; seg < 3; seg++) begin
      for (int j = 0; j < 6; j++) begin
        r++;
        add_step(1, dir ? k[19 - r] : k[r], 64'd0, r);
      end
      if (seg < 2) begin
        if (dir) add_step(2, kl[4 - 2*seg], kl[3 - 2*seg], 0);
        else     add_step(2, kl[1 + 2*seg], kl[2 + 2*seg], 0);
      end
    end
    if (dir) add_step(3, kw[1], kw[2], 0);
    else     add_step(3, kw[3], kw[4], 0);
  endtask

  task automatic rand_keys();
    for (int i = 1; i <= 4; i++) begin
      kw[i] = {$urandom, $urandom};
      kl[i] = {$urandom, $urandom};
    end
    for (int i = 1; i <= 18; i++) k[i] = {$urandom, $urandom};
  endtask

  task automatic run_block(input bit dir, input int ack_pct, input int pre_wait,
                           input int drop_at, input int drop_len, input bit disturb);
    int  pos, cyc, drop_rem;
    bit  kr, kr_prev, exp_valid, exp_done, dropped, finished;
    build_exp(dir);
    pos = 0; cyc = 0; drop_rem = 0; dropped = 0; finished = 0;
    @(negedge CLK);
    kr = (pre_wait == 0);
    start = 1'b1; decrypt = dir; keys_ready = kr; ks.key_ack = 1'b0;
    kr_prev = kr;
    @(negedge CLK);
    start = 1'b0;
    while (!finished && cyc < 400) begin
      if (cyc > 0) @(negedge CLK);
      cyc++;
      exp_valid = kr_prev && (pos < 22);
      exp_done  = (pos == 22);
      check_val($sformatf("valid_c%0d", cyc), ks.key_valid, exp_valid);
      check_val($sformatf("done_c%0d", cyc), done, exp_done);
      check_val($sformatf("busy_c%0d", cyc), busy, !exp_done);
      if (exp_valid) begin
        check_val($sformatf("a_s%0d", pos), ks.key_a, ea[pos]);
        check_val($sformatf("b_s%0d", pos), ks.key_b, eb[pos]);
        check_val($sformatf("kind_s%0d", pos), ks.step_kind, ek[pos]);
        check_val($sformatf("ridx_s%0d", pos), ks.round_idx, ei[pos]);
      end else begin
        check_val("idle_outs", {ks.key_a ^ ks.key_b, 57'd0, ks.step_kind, ks.round_idx}, 64'd0);
      end
      if (exp_done) begin
        if (ack_pct == 100 && pre_wait == 0 && drop_len == 0)
          check_val("done_latency", cyc, 23);
        start = 1'b0;
        ks.key_ack = 1'b0;
        finished = 1;
      end else begin
        if (pre_wait > 0 && cyc == pre_wait) kr = 1'b1;
        if (drop_rem > 0) begin
          drop_rem--;
          if (drop_rem == 0) kr = 1'b1;
        end
        ks.key_ack = ($urandom_range(99) < ack_pct);
        if (exp_valid && pos == drop_at && !dropped && drop_len > 0) begin
          dropped = 1; drop_rem = drop_len; kr = 1'b0; ks.key_ack = 1'b0;
        end
        if (disturb) begin
          start = $urandom_range(1);
          decrypt = $urandom_range(1);
        end
        keys_ready = kr;
        if (exp_valid && ks.key_ack) pos++;
        kr_prev = kr;
      end
    end
    if (!finished) check_val("block_timeout", 0, 1);
    @(negedge CLK);
    check_val("post_idle", {61'd0, ks.key_valid, busy, done}, 64'd0);
  endtask

  initial begin
    RST = 1'b0;
    start = 1'b0; decrypt = 1'b0; keys_ready = 1'b0; ks.key_ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      kw[i] = 64'h2000 + i;
      kl[i] = 64'h3000 + i;
    end
    for (int i = 1; i <= 18; i++) k[i] = 64'h1000 + i;
    #3;
    check_val("rst_valid", ks.key_valid, 0);
    check_val("rst_outs", ks.key_a | ks.key_b | ks.step_kind | ks.round_idx, 0);
    check_val("rst_busy_done", {busy, done}, 0);
    @(negedge CLK);
    RST = 1'b1;

    run_block(0, 100, 0, -1, 0, 0);
    run_block(1, 100, 0, -1, 0, 0);
    rand_keys();
    run_block(0, 30, 0, -1, 0, 0);
    run_block(1, 100, 5, 9, 3, 0);
    run_block(0, 50, 0, -1, 0, 1);

    // Async reset in the middle of a sequence.
    build_exp(0);
    @(negedge CLK);
    start = 1'b1; decrypt = 1'b0; keys_ready = 1'b1; ks.key_ack = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (12) @(negedge CLK);
    check_val("pre_rst_kind", ks.step_kind, 1);
    check_val("pre_rst_ridx", ks.round_idx, 11);
    check_val("pre_rst_a", ks.key_a, ea[12]);
    #2 RST = 1'b0;
    #1;
    check_val("mid_rst_valid", ks.key_valid, 0);
    check_val("mid_rst_outs", ks.key_a | ks.key_b | ks.step_kind | ks.round_idx, 0);
    check_val("mid_rst_busy_done", {busy, done}, 0);
    @(negedge CLK);
    RST = 1'b1;
    ks.key_ack = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      check_val("after_rst", {ks.key_valid, busy, done}, 0);
    end
    run_block(0, 70, 0, -1, 0, 0);

    for (int n = 0; n < 4; n++) begin
      rand_keys();
      run_block($urandom_range(1), 40 + $urandom_range(60), $urandom_range(3),
                $urandom_range(21), $urandom_range(3), $urandom_range(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
